// File: rtl/decode_exec_unit.sv
// decode_exec_unit: D-stage decoder, D->E control register and E-stage
// integer / single-precision FP execute with next-PC select.
module decode_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             stall,
  input  logic             flush,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [3:0]       alu_ctrl_d,
  output logic             alu_src_d,
  output logic [2:0]       imm_src_d,
  output logic             reg_write_d,
  output logic             mem_we_d,
  output logic             is_load_d,
  output logic             result_src_d,
  output logic             wd3_src_d,
  output logic             branch_d,
  output logic             exit_d,
  output logic [1:0]       jump_d,
  output logic             float_alu_d,
  output logic             float_write_d,
  output logic [1:0]       float_read_d,
  output logic [WIDTH-1:0] alu_result_e,
  output logic             eq_e,
  output logic             cmp_e,
  output logic [1:0]       pc_src_e,
  // D->E register contents {alu_ctrl, alu_src, float_alu, branch, jump}
  output logic [8:0]       e_state
);
  localparam logic [4:0] OP_R    = 5'b00001, OP_I   = 5'b00010, OP_LW  = 5'b00011;
  localparam logic [4:0] OP_SW   = 5'b00100, OP_BEQ = 5'b00101, OP_JMP = 5'b00110;
  localparam logic [4:0] OP_CALL = 5'b00111, OP_RET = 5'b01000, OP_FR  = 5'b01001;
  localparam logic [4:0] OP_FLW  = 5'b01010, OP_FSW = 5'b01011, OP_EXIT = 5'b11111;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic [4:0] opcode;
  logic [3:0] funct;
  assign opcode = instr[31:27];
  assign funct  = instr[26:23];

  // Combinational decode; anything not set for an opcode stays 0.
  always_comb begin
    alu_ctrl_d = 4'd0; alu_src_d = 1'b0; imm_src_d = 3'd0; reg_write_d = 1'b0;
    mem_we_d = 1'b0; is_load_d = 1'b0; result_src_d = 1'b0; wd3_src_d = 1'b0;
    branch_d = 1'b0; exit_d = 1'b0; jump_d = 2'b00; float_alu_d = 1'b0;
    float_write_d = 1'b0; float_read_d = 2'b00;
    case (opcode)
      OP_R:    begin alu_ctrl_d = funct; reg_write_d = 1'b1; end
      OP_I:    begin alu_ctrl_d = funct; alu_src_d = 1'b1; reg_write_d = 1'b1; end
      OP_LW, OP_FLW: begin
        alu_src_d = 1'b1; reg_write_d = 1'b1; is_load_d = 1'b1; result_src_d = 1'b1;
        float_write_d = (opcode == OP_FLW);
      end
      OP_SW, OP_FSW: begin
        alu_src_d = 1'b1; imm_src_d = 3'b001; mem_we_d = 1'b1;
        float_read_d = (opcode == OP_FSW) ? 2'b10 : 2'b00;
      end
      OP_BEQ:  begin alu_ctrl_d = 4'd1; branch_d = 1'b1; imm_src_d = 3'b010; end
      OP_JMP:  begin jump_d = 2'b10; imm_src_d = 3'b011; end
      OP_CALL: begin jump_d = 2'b10; imm_src_d = 3'b011; reg_write_d = 1'b1; wd3_src_d = 1'b1; end
      OP_RET:  begin alu_src_d = 1'b1; jump_d = 2'b11; end
      OP_FR: begin
        float_alu_d = 1'b1; alu_ctrl_d = funct; float_read_d = 2'b01; reg_write_d = 1'b1;
        // FP compares produce an integer flag, so they target the int regfile
        float_write_d = !((funct == 4'h3) || (funct == 4'h4) || (funct == 4'h5));
      end
      OP_EXIT: exit_d = 1'b1;
      default: ;
    endcase
  end

  logic [3:0] alu_ctrl_q;
  logic       alu_src_q, float_alu_q, branch_q;
  logic [1:0] jump_q;

  // D->E register: flush beats stall, stall holds, else capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_ctrl_q <= 4'd0; alu_src_q <= 1'b0; float_alu_q <= 1'b0; branch_q <= 1'b0; jump_q <= 2'b00;
    end else if (flush) begin
      alu_ctrl_q <= 4'd0; alu_src_q <= 1'b0; float_alu_q <= 1'b0; branch_q <= 1'b0; jump_q <= 2'b00;
    end else if (!stall) begin
      alu_ctrl_q <= alu_ctrl_d; alu_src_q <= alu_src_d; float_alu_q <= float_alu_d;
      branch_q <= branch_d; jump_q <= jump_d;
    end
  end

  assign e_state = {alu_ctrl_q, alu_src_q, float_alu_q, branch_q, jump_q};

  // ---------------- FP helpers (subnormals flush to zero, round toward zero)
  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction
  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction
  function automatic logic is_zero(input logic [31:0] x);
    return (x[30:23] == 8'd0);
  endfunction
  // Exponent range check: below 1 becomes signed zero, 255 and up becomes infinity.
  function automatic logic [31:0] pack(input logic s, input int e, input logic [22:0] f);
    if (e <= 0) return {s, 31'd0};
    else if (e >= 255) return {s, 8'hFF, 23'd0};
    else return {s, e[7:0], f};
  endfunction
  // Totally ordered integer key; both zeros map to 0 so +0 == -0.
  function automatic logic signed [31:0] fp_key(input logic [31:0] x);
    logic signed [31:0] mag;
    mag = signed'({1'b0, x[30:0]});
    if (is_zero(x)) return 32'sd0;
    return x[31] ? -mag : mag;
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [27:0] mx, my, sum, norm;
    logic [7:0]  d;
    logic        sticky;
    int          p;
    if (is_nan(a) || is_nan(b)) return QNAN;
    if (is_inf(a) && is_inf(b)) return (a[31] == b[31]) ? a : QNAN;
    if (is_inf(a)) return a;
    if (is_inf(b)) return b;
    if (is_zero(a) && is_zero(b)) return {a[31] & b[31], 31'd0};
    if (is_zero(a)) return b;
    if (is_zero(b)) return a;
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end
    else begin x = b; y = a; end
    d  = x[30:23] - y[30:23];
    // hidden bit at [26], carry room at [27], three guard bits with sticky at [0]
    mx = {2'b01, x[22:0], 3'b000};
    my = {2'b01, y[22:0], 3'b000};
    if (d >= 8'd27) my = 28'd1;
    else begin
      sticky = |(my & ((28'd1 << d) - 28'd1));
      my = (my >> d) | {27'd0, sticky};
    end
    sum = (x[31] == y[31]) ? (mx + my) : (mx - my);
    if (sum == 28'd0) return 32'd0;
    p = 0;
    for (int i = 0; i < 28; i++) if (sum[i]) p = i;
    norm = sum << (27 - p);
    return pack(x[31], int'(x[30:23]) + p - 26, norm[26:4]);
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] ma, mb, prod;
    logic        s;
    int          e;
    s = a[31] ^ b[31];
    if (is_nan(a) || is_nan(b)) return QNAN;
    if ((is_inf(a) && is_zero(b)) || (is_zero(a) && is_inf(b))) return QNAN;
    if (is_inf(a) || is_inf(b)) return {s, 8'hFF, 23'd0};
    if (is_zero(a) || is_zero(b)) return {s, 31'd0};
    ma   = {24'd0, 1'b1, a[22:0]};
    mb   = {24'd0, 1'b1, b[22:0]};
    prod = ma * mb;
    e    = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (prod[47]) return pack(s, e + 1, prod[46:24]);
    return pack(s, e, prod[45:23]);
  endfunction

  logic [31:0] int_result, fp_result;
  logic        fp_cmp, any_nan;
  logic signed [31:0] key_a, key_b;

  assign eq_e    = (src_a == src_b);
  assign any_nan = is_nan(src_a) || is_nan(src_b);
  assign key_a   = fp_key(src_a);
  assign key_b   = fp_key(src_b);

  // Integer ALU.
  always_comb begin
    int_result = 32'd0;
    case (alu_ctrl_q)
      4'h0: int_result = src_a + src_b;
      4'h1: int_result = src_a - src_b;
      4'h2: int_result = src_a & src_b;
      4'h3: int_result = src_a | src_b;
      4'h4: int_result = src_a ^ src_b;
      4'h5: int_result = src_a << src_b[4:0];
      4'h6: int_result = src_a >> src_b[4:0];
      4'h7: int_result = $signed(src_a) >>> src_b[4:0];
      4'h8: int_result = {31'd0, $signed(src_a) < $signed(src_b)};
      4'h9: int_result = {31'd0, src_a < src_b};
      4'hA: int_result = src_a * src_b;
      4'hB: int_result = src_b;
      default: int_result = 32'd0;
    endcase
  end

  // FP ALU; compares return 0/1 and are forced to 0 on any NaN.
  always_comb begin
    fp_result = 32'd0;
    fp_cmp    = 1'b0;
    case (alu_ctrl_q)
      4'h0: fp_result = fp_add(src_a, src_b);
      4'h1: fp_result = fp_add(src_a, {~src_b[31], src_b[30:0]});
      4'h2: fp_result = fp_mul(src_a, src_b);
      4'h3: fp_cmp = !any_nan && (key_a == key_b);
      4'h4: fp_cmp = !any_nan && (key_a <  key_b);
      4'h5: fp_cmp = !any_nan && (key_a <= key_b);
      4'h6: fp_result = any_nan ? QNAN : ((key_a < key_b) ? src_a : src_b);
      4'h7: fp_result = any_nan ? QNAN : ((key_a > key_b) ? src_a : src_b);
      // sign manipulations are pure bit operations
      4'h8: fp_result = {~src_a[31], src_a[30:0]};
      4'h9: fp_result = {1'b0, src_a[30:0]};
      default: fp_result = 32'd0;
    endcase
    if ((alu_ctrl_q == 4'h3) || (alu_ctrl_q == 4'h4) || (alu_ctrl_q == 4'h5))
      fp_result = {31'd0, fp_cmp};
  end

  assign alu_result_e = float_alu_q ? fp_result : int_result;
  assign cmp_e        = float_alu_q & fp_cmp;

  // Next-PC select: RET target, then jump, then taken branch.
  always_comb begin
    pc_src_e = 2'b00;
    if (jump_q == 2'b11)          pc_src_e = 2'b10;
    else if (jump_q == 2'b10)     pc_src_e = 2'b01;
    else if (branch_q && eq_e)    pc_src_e = 2'b01;
  end
endmodule

// File: tb/tb_decode_exec_unit.sv
// Self-checking bench for decode_exec_unit.
module tb_decode_exec_unit;
  logic        clk, rst, stall, flush;
  logic [31:0] instr, src_a, src_b;
  logic [3:0]  alu_ctrl_d;
  logic        alu_src_d, reg_write_d, mem_we_d, is_load_d, result_src_d, wd3_src_d;
  logic        branch_d, exit_d, float_alu_d, float_write_d;
  logic [2:0]  imm_src_d;
  logic [1:0]  jump_d, float_read_d, pc_src_e;
  logic [31:0] alu_result_e;
  logic        eq_e, cmp_e;
  logic [8:0]  e_state;

  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  decode_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .instr(instr), .stall(stall), .flush(flush),
    .src_a(src_a), .src_b(src_b),
    .alu_ctrl_d(alu_ctrl_d), .alu_src_d(alu_src_d), .imm_src_d(imm_src_d),
    .reg_write_d(reg_write_d), .mem_we_d(mem_we_d), .is_load_d(is_load_d),
    .result_src_d(result_src_d), .wd3_src_d(wd3_src_d), .branch_d(branch_d),
    .exit_d(exit_d), .jump_d(jump_d), .float_alu_d(float_alu_d),
    .float_write_d(float_write_d), .float_read_d(float_read_d),
    .alu_result_e(alu_result_e), .eq_e(eq_e), .cmp_e(cmp_e), .pc_src_e(pc_src_e),
    .e_state(e_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] mk(input logic [3:0] alu, input logic asrc, input logic [2:0] imm,
                                     input logic rw, input logic mwe, input logic ld, input logic rs,
                                     input logic wd3, input logic br, input logic ex,
                                     input logic [1:0] jmp, input logic fa, input logic fw,
                                     input logic [1:0] fr);
    return {11'd0, alu, asrc, imm, rw, mwe, ld, rs, wd3, br, ex, jmp, fa, fw, fr};
  endfunction

  function automatic logic [31:0] dec_vec();
    return {11'd0, alu_ctrl_d, alu_src_d, imm_src_d, reg_write_d, mem_we_d, is_load_d,
            result_src_d, wd3_src_d, branch_d, exit_d, jump_d, float_alu_d, float_write_d,
            float_read_d};
  endfunction

  function automatic logic [31:0] int_model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return a << b[4:0];
      4'h6: return a >> b[4:0];
      4'h7: return $signed(a) >>> b[4:0];
      4'h8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h9: return (a < b) ? 32'd1 : 32'd0;
      4'hA: return a * b;
      4'hB: return b;
      default: return 32'd0;
    endcase
  endfunction

  // Decode is combinational: drive instr, settle, compare.
  task automatic dec_check(input string tag, input logic [31:0] ins, input logic [31:0] exp);
    exp_q.push_back(exp);
    instr = ins;
    #1;
    check_val(tag, dec_vec(), exp_q.pop_front());
  endtask

  // Capture ins into the E register, then apply operands and compare the E-stage outputs.
  task automatic exec_op(input string tag, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input logic [1:0] exp_pc, input logic exp_cmp);
    exp_q.push_back(exp_res);
    exp_q.push_back({28'd0, exp_pc, exp_cmp, a == b});
    instr = ins;
    @(posedge clk);
    @(negedge clk);
    src_a = a;
    src_b = b;
    #1;
    check_val({tag, "_res"}, alu_result_e, exp_q.pop_front());
    check_val({tag, "_pc_cmp_eq"}, {28'd0, pc_src_e, cmp_e, eq_e}, exp_q.pop_front());
  endtask

  task automatic state_check(input string tag, input logic [8:0] exp);
    exp_q.push_back({23'd0, exp});
    check_val(tag, {23'd0, e_state}, exp_q.pop_front());
  endtask

  initial begin
    logic [3:0]  f;
    logic [31:0] a, b;
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    instr = 32'h0800_0000; src_a = 32'd0; src_b = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    state_check("reset_e_state", 9'd0);
    check_val("reset_pc", {30'd0, pc_src_e}, 32'd0);
    rst = 1'b1;

    // decode table
    dec_check("dec_nop",   32'h0000_0000, mk(0,0,0,0,0,0,0,0,0,0,2'b00,0,0,2'b00));
    dec_check("dec_r_sll", 32'h0A80_0000, mk(5,0,0,1,0,0,0,0,0,0,2'b00,0,0,2'b00));
    dec_check("dec_i",     32'h1180_0000, mk(3,1,0,1,0,0,0,0,0,0,2'b00,0,0,2'b00));
    dec_check("dec_lw",    32'h1800_0000, mk(0,1,0,1,0,1,1,0,0,0,2'b00,0,0,2'b00));
    dec_check("dec_sw",    32'h2000_0000, mk(0,1,1,0,1,0,0,0,0,0,2'b00,0,0,2'b00));
    dec_check("dec_beq",   32'h2880_0000, mk(1,0,2,0,0,0,0,0,1,0,2'b00,0,0,2'b00));
    dec_check("dec_jmp",   32'h3000_0000, mk(0,0,3,0,0,0,0,0,0,0,2'b10,0,0,2'b00));
    dec_check("dec_call",  32'h3800_0000, mk(0,0,3,1,0,0,0,1,0,0,2'b10,0,0,2'b00));
    dec_check("dec_ret",   32'h4000_0000, mk(0,1,0,0,0,0,0,0,0,0,2'b11,0,0,2'b00));
    dec_check("dec_fadd",  32'h4800_0000, mk(0,0,0,1,0,0,0,0,0,0,2'b00,1,1,2'b01));
    dec_check("dec_flt",   32'h4A00_0000, mk(4,0,0,1,0,0,0,0,0,0,2'b00,1,0,2'b01));
    dec_check("dec_flw",   32'h5000_0000, mk(0,1,0,1,0,1,1,0,0,0,2'b00,0,1,2'b00));
    dec_check("dec_fsw",   32'h5800_0000, mk(0,1,1,0,1,0,0,0,0,0,2'b00,0,0,2'b10));
    dec_check("dec_exit",  32'hF800_0000, mk(0,0,0,0,0,0,0,0,0,1,2'b00,0,0,2'b00));
    dec_check("dec_undef", 32'h6780_0000, mk(0,0,0,0,0,0,0,0,0,0,2'b00,0,0,2'b00));

    // integer execute and PC select
    exec_op("add",      32'h0800_0000, 32'd5, 32'd7, 32'd12, 2'b00, 1'b0);
    exec_op("sub",      32'h0880_0000, 32'd5, 32'd7, 32'hFFFF_FFFE, 2'b00, 1'b0);
    state_check("sub_e_state", 9'd32);
    exec_op("beq_taken", 32'h2880_0000, 32'h10, 32'h10, 32'd0, 2'b01, 1'b0);
    exec_op("beq_not",   32'h2880_0000, 32'h10, 32'h11, 32'hFFFF_FFFF, 2'b00, 1'b0);
    exec_op("call",      32'h3800_0000, 32'd100, 32'd4, 32'd104, 2'b01, 1'b0);
    exec_op("ret",       32'h4000_0000, 32'd1, 32'd2, 32'd3, 2'b10, 1'b0);
    state_check("ret_e_state", 9'd19);

    // asynchronous reset mid-run, away from any clock edge
    rst = 1'b0;
    #1;
    src_a = 32'd3; src_b = 32'd4;
    #1;
    state_check("midrst_e_state", 9'd0);
    check_val("midrst_pc", {30'd0, pc_src_e}, 32'd0);
    check_val("midrst_add", alu_result_e, 32'd7);
    @(negedge clk);
    rst = 1'b1;

    // stall holds, flush wins over stall
    exec_op("pre_stall", 32'h0880_0000, 32'd5, 32'd7, 32'hFFFF_FFFE, 2'b00, 1'b0);
    stall = 1'b1;
    exec_op("stall", 32'h2880_0000, 32'd9, 32'd9, 32'd0, 2'b00, 1'b0);
    state_check("stall_e_state", 9'd32);
    flush = 1'b1;
    exec_op("flush", 32'h0880_0000, 32'd5, 32'd7, 32'd12, 2'b00, 1'b0);
    state_check("flush_e_state", 9'd0);
    stall = 1'b0;
    flush = 1'b0;

    // floating point
    exec_op("fadd",      32'h4800_0000, 32'h3FC0_0000, 32'h4010_0000, 32'h4070_0000, 2'b00, 1'b0);
    exec_op("fmul",      32'h4900_0000, 32'h3FC0_0000, 32'h4010_0000, 32'h4058_0000, 2'b00, 1'b0);
    exec_op("fsub_zero", 32'h4880_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 2'b00, 1'b0);
    exec_op("fsub_neg",  32'h4880_0000, 32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 2'b00, 1'b0);
    exec_op("fadd_rz",   32'h4800_0000, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 2'b00, 1'b0);
    exec_op("fsub_rz",   32'h4880_0000, 32'h3F80_0000, 32'h3300_0000, 32'h3F7F_FFFF, 2'b00, 1'b0);
    exec_op("fmul_ovf",  32'h4900_0000, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 2'b00, 1'b0);
    exec_op("fmul_unf",  32'h4900_0000, 32'h8080_0000, 32'h0080_0000, 32'h8000_0000, 2'b00, 1'b0);
    exec_op("fadd_sub",  32'h4800_0000, 32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000, 2'b00, 1'b0);
    exec_op("fadd_nan",  32'h4800_0000, 32'hFF80_0001, 32'h3F80_0000, 32'h7FC0_0000, 2'b00, 1'b0);
    exec_op("flt",       32'h4A00_0000, 32'h3F80_0000, 32'h4000_0000, 32'd1, 2'b00, 1'b1);
    exec_op("feq_nan",   32'h4980_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'd0, 2'b00, 1'b0);
    exec_op("feq_zeros", 32'h4980_0000, 32'h0000_0000, 32'h8000_0000, 32'd1, 2'b00, 1'b1);
    exec_op("fle_false", 32'h4A80_0000, 32'hBF80_0000, 32'hC000_0000, 32'd0, 2'b00, 1'b0);
    exec_op("fle_equal", 32'h4A80_0000, 32'h4000_0000, 32'h4000_0000, 32'd1, 2'b00, 1'b1);
    exec_op("fmin",      32'h4B00_0000, 32'hBF80_0000, 32'h3F00_0000, 32'hBF80_0000, 2'b00, 1'b0);
    exec_op("fmax",      32'h4B80_0000, 32'hBF80_0000, 32'h3F00_0000, 32'h3F00_0000, 2'b00, 1'b0);
    exec_op("fneg",      32'h4C00_0000, 32'h3FC0_0000, 32'h0000_0000, 32'hBFC0_0000, 2'b00, 1'b0);
    exec_op("fabs",      32'h4C80_0000, 32'hC000_0000, 32'h0000_0000, 32'h4000_0000, 2'b00, 1'b0);
    exec_op("fp_undef",  32'h4D00_0000, 32'h3F80_0000, 32'h3F80_0000, 32'd0, 2'b00, 1'b0);

    // random integer R-type ops, including undefined functs and equal operands
    for (int i = 0; i < 24; i++) begin
      f = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      exec_op($sformatf("rnd_f%0h", f), {5'b00001, f, 23'd0}, a, b, int_model(f, a, b), 2'b00, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
